// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch-stage PC control path.
// PC source encoding doubles as redirect priority (oldest pipeline stage wins).
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_JUMP   = 2'd1,
        PC_JR     = 2'd2,
        PC_BRANCH = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } pcseq_state_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
    } flush_t;

    // A redirect squashes every younger latch between its stage and fetch.
    function automatic flush_t flush_for(input pcsrc_t src);
        flush_t f;
        f.ifid  = (src != PC_SEQ);
        f.idex  = (src == PC_JR) || (src == PC_BRANCH);
        f.exmem = (src == PC_BRANCH);
        return f;
    endfunction

endpackage

// File: rtl/pc_redirect_prio.sv
// Picks the oldest active redirect among branch (MEM), JR (EX) and jump (ID).
module pc_redirect_prio
    import cpu_types_pkg::*;
(
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output pcsrc_t      src,
    output logic [31:0] target
);

    always_comb begin
        src    = PC_SEQ;
        target = '0;
        if (br_taken) begin
            src    = PC_BRANCH;
            target = br_target;
        end else if (jr_valid) begin
            src    = PC_JR;
            target = jr_target;
        end else if (jmp_valid) begin
            src    = PC_JUMP;
            target = jmp_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC controller: next PC / enable, redirect arbitration with a pending
// slot for redirects arriving during an imem miss, pipeline flushes and halt.
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned PC_STEP = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      current_pc,
    input  logic             ihit,
    input  logic             hazard_stall,
    input  logic             halt,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             jr_valid,
    input  logic [31:0]      jr_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    output logic [31:0]      next_pc,
    output logic             pc_en,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_exmem,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    pcseq_state_t state, state_next;
    pcsrc_t       pend_src, pend_src_next;
    logic [31:0]  pend_target, pend_target_next;
    pcsrc_t       win_src, eff_src;
    logic [31:0]  win_target, eff_target;
    logic [31:0]  seq_pc;
    logic         cnt_inc;
    flush_t       flush;

    pc_redirect_prio u_prio (
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .src        (win_src),
        .target     (win_target)
    );

    assign seq_pc      = current_pc + 32'(PC_STEP);
    assign flush_ifid  = flush.ifid;
    assign flush_idex  = flush.idex;
    assign flush_exmem = flush.exmem;
    assign halted      = (state == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state        <= RUN;
            pend_src     <= PC_SEQ;
            pend_target  <= '0;
            redirect_cnt <= '0;
        end else begin
            state       <= state_next;
            pend_src    <= pend_src_next;
            pend_target <= pend_target_next;
            if (cnt_inc && (redirect_cnt != '1))
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held so the PC register sees no stray load.
    always_comb begin
        state_next       = state;
        pend_src_next    = pend_src;
        pend_target_next = pend_target;
        eff_src          = pend_src;
        eff_target       = pend_target;
        cnt_inc          = 1'b0;
        next_pc          = seq_pc;
        pc_en            = 1'b0;
        flush            = flush_for(PC_SEQ);

        if (!nRST) begin
            state_next = RUN;
        end else if (halt) begin
            state_next    = HALT;
            pend_src_next = PC_SEQ;
        end else begin
            case (state)
                RUN: begin
                    if (win_src != PC_SEQ) begin
                        flush   = flush_for(win_src);
                        next_pc = win_target;
                        if (ihit) begin
                            pc_en   = 1'b1;
                            cnt_inc = 1'b1;
                        end else begin
                            state_next       = PEND;
                            pend_src_next    = win_src;
                            pend_target_next = win_target;
                        end
                    end else begin
                        pc_en = ihit & ~hazard_stall;
                    end
                end
                PEND: begin
                    // Only an older instruction's redirect may replace the held one.
                    if (win_src > pend_src) begin
                        flush      = flush_for(win_src);
                        eff_src    = win_src;
                        eff_target = win_target;
                    end
                    next_pc = eff_target;
                    pc_en   = ihit;
                    if (ihit) begin
                        state_next    = RUN;
                        pend_src_next = PC_SEQ;
                        cnt_inc       = 1'b1;
                    end else begin
                        pend_src_next    = eff_src;
                        pend_target_next = eff_target;
                    end
                end
                default: begin
                    state_next = HALT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Controls the fetch-stage program counter register: computes its next value and its update enable every cycle.
- Sits between the hazard unit, the redirect sources and the PC register. Redirect sources are jump in ID, JR in EX and taken branch in MEM.
- Arbitrates simultaneous redirects, holds a redirect that cannot be applied while instruction memory is busy, and generates the matching pipeline-flush signals.
- Owns the halted state.

Parameters:
- CNT_W, 16, width of the saturating redirect counter.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- CLK  input  1  system clock
- nRST  input  1  asynchronous active-low reset
- current_pc  input  32  present value of the PC register
- ihit  input  1  instruction memory returned the fetch this cycle
- hazard_stall  input  1  load-use stall request from the hazard unit
- halt  input  1  halt instruction reached WB
- br_taken  input  1  MEM-stage branch resolved taken
- br_target  input  32  branch target
- jr_valid  input  1  EX-stage JR
- jr_target  input  32  register target
- jmp_valid  input  1  ID-stage J/JAL
- jmp_target  input  32  jump target
- next_pc  output  32  value loaded into the PC register
- pc_en  output  1  PC register update enable
- flush_ifid  output  1  clear IF/ID latch
- flush_idex  output  1  clear ID/EX latch
- flush_exmem  output  1  clear EX/MEM latch
- halted  output  1  core halted
- redirect_cnt  output  CNT_W  number of applied redirects, saturating

Behaviour:
- States: RUN, PEND, HALT. On reset: state RUN, pending target 0, pending source PC_SEQ, redirect_cnt 0.
- Reset values of registered outputs: halted 0.
- Reset values of combinational outputs: next_pc = current_pc+4, and pc_en, all flushes = 0 while nRST is low.
- Priority, oldest first: BRANCH > JR > JUMP > SEQ.
- Flushes are combinational and asserted in the cycle the source is accepted, regardless of ihit:
  - BRANCH flushes IF/ID, ID/EX and EX/MEM.
  - JR flushes IF/ID and ID/EX.
  - JUMP flushes IF/ID only.
- Sequential PC: next_pc = current_pc + PC_STEP, modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
- RUN, no redirect: next_pc is the sequential PC; pc_en = ihit & ~hazard_stall.
- RUN, redirect with ihit=1:
  - next_pc = winning target, pc_en = 1.
  - hazard_stall is ignored, because the stalled instruction is squashed.
  - redirect_cnt increments.
- RUN, redirect with ihit=0:
  - Latch winning target and source into pending registers; go to PEND.
  - pc_en = 0; flushes are still asserted this cycle.
- PEND:
  - next_pc = pending target; pc_en = ihit.
  - When ihit=1: return to RUN and increment redirect_cnt.
  - A new redirect of strictly higher priority than the pending source overwrites target and source and asserts its flushes. This applies in the same cycle; if ihit=1 that cycle, the new target is used directly.
  - Equal- or lower-priority redirects are ignored and produce no flushes.
- HALT:
  - Entered in the cycle after halt=1 is seen in any state; halt has top priority.
  - In the halt cycle itself: pc_en = 0, no flushes, any pending redirect is dropped.
  - In HALT: halted = 1, pc_en = 0, flushes = 0. Only reset leaves HALT.
- redirect_cnt saturates at all-ones.
- Reset asserted in PEND discards the pending redirect immediately.

Decomposition:
- cpu_types_pkg gains:
  - typedef enum logic [1:0] pcsrc_t {PC_SEQ=0, PC_JUMP=1, PC_JR=2, PC_BRANCH=3}. The encoding order equals priority, so "strictly higher" is a numeric compare.
  - typedef enum pcseq_state_t {RUN, PEND, HALT}.
- One combinational sub-module, pc_redirect_prio. Inputs: the three valid/target pairs. Outputs: winning pcsrc_t and target.

Test Plan:
- Reset, ihit=1, current_pc stepping 0,4,8 -> next_pc 4,8,C; pc_en=1; no flushes. current_pc=0xFFFFFFFC -> next_pc=0.
- hazard_stall=1, ihit=1, no redirect -> pc_en=0. With br_taken=1 and target 0x40 in the same cycle -> pc_en=1, next_pc=0x40, all three flushes=1, redirect_cnt=1.
- jmp_valid (0x100), jr_valid (0x200) and br_taken (0x300) in the same cycle, ihit=1 -> next_pc=0x300, flush_exmem=1.
- jmp_valid (0x100) with ihit=0 -> PEND, flush_ifid=1, pc_en=0. Next cycle jr_valid (0x200), ihit=0 -> overwrite, flush_idex=1. Next cycle ihit=1 -> next_pc=0x200, pc_en=1, back to RUN.
- Pending JR then jmp_valid in PEND -> ignored, no flush. halt=1 during PEND -> halted=1 next cycle, pc_en=0 thereafter; deassert nRST -> RUN, halted=0, redirect_cnt=0.
- Apply 2^CNT_W+3 redirects -> redirect_cnt holds 0xFFFF.
